// File: rtl/scr1_mem_copy_initiator.sv
// Single-channel word copy engine acting as an initiator on the SCR1 data-memory interface.
// One transaction is outstanding at a time: read a word, write it, repeat until len words are moved.

package scr1_memif_pkg;

    localparam int SCR1_DMEM_AWIDTH = 32;
    localparam int SCR1_DMEM_DWIDTH = 32;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

endpackage

module scr1_mem_copy_initiator
    import scr1_memif_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [SCR1_DMEM_AWIDTH-1:0] src_addr,
    input  logic [SCR1_DMEM_AWIDTH-1:0] dst_addr,
    input  logic [LEN_W-1:0]            len,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [SCR1_DMEM_AWIDTH-1:0] err_addr,
    output logic                        dmem_req,
    input  logic                        dmem_req_ack,
    output type_scr1_mem_cmd_e          dmem_cmd,
    output type_scr1_mem_width_e        dmem_width,
    output logic [SCR1_DMEM_AWIDTH-1:0] dmem_addr,
    output logic [SCR1_DMEM_DWIDTH-1:0] dmem_wdata,
    input  logic [SCR1_DMEM_DWIDTH-1:0] dmem_rdata,
    input  type_scr1_mem_resp_e         dmem_resp
);

    localparam int AW = SCR1_DMEM_AWIDTH;
    localparam int DW = SCR1_DMEM_DWIDTH;
    localparam logic [AW-1:0]    WORD_BYTES = AW'(4);
    localparam logic [LEN_W-1:0] ONE_WORD   = LEN_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_RESP,
        WR_REQ,
        WR_RESP
    } state_e;

    state_e             state, state_n;
    logic [AW-1:0]      rd_ptr, rd_ptr_n;
    logic [AW-1:0]      wr_ptr, wr_ptr_n;
    logic [LEN_W-1:0]   cnt, cnt_n;
    logic               busy_n, done_n, err_n, req_n;
    logic [AW-1:0]      err_addr_n, addr_n;
    logic [DW-1:0]      wdata_n;
    type_scr1_mem_cmd_e cmd_n;

    // Byte-offset bits of the start addresses are deliberately dropped.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{src_addr[1:0], dst_addr[1:0]};

    assign dmem_width = SCR1_MEM_WIDTH_WORD;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
        state_n    = state;
        rd_ptr_n   = rd_ptr;
        wr_ptr_n   = wr_ptr;
        cnt_n      = cnt;
        busy_n     = busy;
        done_n     = 1'b0;
        err_n      = 1'b0;
        err_addr_n = err_addr;
        req_n      = dmem_req;
        cmd_n      = dmem_cmd;
        addr_n     = dmem_addr;
        wdata_n    = dmem_wdata;

        case (state)
            IDLE: begin
                if (start) begin
                    err_addr_n = '0;
                    if (len != '0) begin
                        rd_ptr_n = {src_addr[AW-1:2], 2'b00};
                        wr_ptr_n = {dst_addr[AW-1:2], 2'b00};
                        cnt_n    = len;
                        busy_n   = 1'b1;
                        req_n    = 1'b1;
                        cmd_n    = SCR1_MEM_CMD_RD;
                        addr_n   = {src_addr[AW-1:2], 2'b00};
                        state_n  = RD_REQ;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end

            RD_REQ: begin
                if (dmem_req && dmem_req_ack) begin
                    req_n   = 1'b0;
                    state_n = RD_RESP;
                end
            end

            RD_RESP: begin
                if (dmem_resp == SCR1_MEM_RESP_RDY_OK) begin
                    wdata_n  = dmem_rdata;
                    rd_ptr_n = rd_ptr + WORD_BYTES;
                    req_n    = 1'b1;
                    cmd_n    = SCR1_MEM_CMD_WR;
                    addr_n   = wr_ptr;
                    state_n  = WR_REQ;
                end else if (dmem_resp == SCR1_MEM_RESP_RDY_ER) begin
                    err_n      = 1'b1;
                    err_addr_n = dmem_addr;
                    busy_n     = 1'b0;
                    state_n    = IDLE;
                end
            end

            WR_REQ: begin
                if (dmem_req && dmem_req_ack) begin
                    req_n   = 1'b0;
                    state_n = WR_RESP;
                end
            end

            WR_RESP: begin
                if (dmem_resp == SCR1_MEM_RESP_RDY_OK) begin
                    wr_ptr_n = wr_ptr + WORD_BYTES;
                    cnt_n    = cnt - ONE_WORD;
                    if (cnt == ONE_WORD) begin
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        req_n   = 1'b1;
                        cmd_n   = SCR1_MEM_CMD_RD;
                        addr_n  = rd_ptr;
                        state_n = RD_REQ;
                    end
                end else if (dmem_resp == SCR1_MEM_RESP_RDY_ER) begin
                    err_n      = 1'b1;
                    err_addr_n = dmem_addr;
                    busy_n     = 1'b0;
                    state_n    = IDLE;
                end
            end

            default: begin
                busy_n  = 1'b0;
                req_n   = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_addr   <= '0;
            dmem_req   <= 1'b0;
            dmem_cmd   <= SCR1_MEM_CMD_RD;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state      <= state_n;
            rd_ptr     <= rd_ptr_n;
            wr_ptr     <= wr_ptr_n;
            cnt        <= cnt_n;
            busy       <= busy_n;
            done       <= done_n;
            err        <= err_n;
            err_addr   <= err_addr_n;
            dmem_req   <= req_n;
            dmem_cmd   <= cmd_n;
            dmem_addr  <= addr_n;
            dmem_wdata <= wdata_n;
        end
    end

endmodule

// File: tb/tb_scr1_mem_copy_initiator.sv
// Directed bench for scr1_mem_copy_initiator with a configurable-latency TCM-style responder.
// Cycle k is the interval after edge k-1; start is sampled at edge 0.

module tb_scr1_mem_copy_initiator;
    import scr1_memif_pkg::*;

    localparam int AW = SCR1_DMEM_AWIDTH;
    localparam int DW = SCR1_DMEM_DWIDTH;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic [AW-1:0]        src_addr = '0;
    logic [AW-1:0]        dst_addr = '0;
    logic [15:0]          len = '0;
    logic                 busy, done, err;
    logic [AW-1:0]        err_addr;
    logic                 dmem_req, dmem_req_ack;
    type_scr1_mem_cmd_e   dmem_cmd;
    type_scr1_mem_width_e dmem_width;
    logic [AW-1:0]        dmem_addr;
    logic [DW-1:0]        dmem_wdata, dmem_rdata;
    type_scr1_mem_resp_e  dmem_resp;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    scr1_mem_copy_initiator #(.LEN_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .len(len), .busy(busy), .done(done), .err(err), .err_addr(err_addr),
        .dmem_req(dmem_req), .dmem_req_ack(dmem_req_ack), .dmem_cmd(dmem_cmd),
        .dmem_width(dmem_width), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- responder model ----------------
    int            ack_wait = 0;
    int            resp_wait = 0;
    logic          err_wr_en = 1'b0;
    logic [AW-1:0] err_wr_addr = '0;

    int                  ack_cnt, pend_cnt;
    logic                pend;
    type_scr1_mem_resp_e pend_resp, acc_resp;
    logic [DW-1:0]       pend_rdata, acc_rdata;
    logic                acc_is_err;

    function automatic logic [31:0] src_word(input logic [31:0] a);
        case (a)
            32'h100: return 32'h11111111;
            32'h104: return 32'h22222222;
            32'h108: return 32'h33333333;
            32'h10C: return 32'h44444444;
            32'h110: return 32'h55555555;
            default: return a ^ 32'hA5A50000;
        endcase
    endfunction

    assign dmem_req_ack = (ack_cnt >= ack_wait);
    assign acc_is_err   = (dmem_cmd == SCR1_MEM_CMD_WR) && err_wr_en && (dmem_addr == err_wr_addr);
    assign acc_resp     = acc_is_err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
    assign acc_rdata    = (dmem_cmd == SCR1_MEM_CMD_RD) ? src_word(dmem_addr) : 32'h0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_cnt    <= 0;
            pend       <= 1'b0;
            pend_cnt   <= 0;
            pend_resp  <= SCR1_MEM_RESP_NOTRDY;
            pend_rdata <= '0;
            dmem_resp  <= SCR1_MEM_RESP_NOTRDY;
            dmem_rdata <= '0;
        end else begin
            dmem_resp <= SCR1_MEM_RESP_NOTRDY;
            if (dmem_req && dmem_req_ack) begin
                ack_cnt <= 0;
                if (resp_wait == 0) begin
                    dmem_resp  <= acc_resp;
                    dmem_rdata <= acc_rdata;
                end else begin
                    pend       <= 1'b1;
                    pend_cnt   <= resp_wait;
                    pend_resp  <= acc_resp;
                    pend_rdata <= acc_rdata;
                end
            end else begin
                if (dmem_req) ack_cnt <= ack_cnt + 1;
                if (pend) begin
                    pend_cnt <= pend_cnt - 1;
                    if (pend_cnt == 1) begin
                        pend       <= 1'b0;
                        dmem_resp  <= pend_resp;
                        dmem_rdata <= pend_rdata;
                    end
                end
            end
        end
    end

    // Accepted reads and successful writes, in order.
    logic [31:0] rd_log   [256];
    logic [31:0] wr_log_a [256];
    logic [31:0] wr_log_d [256];
    int rd_n = 0;
    int wr_n = 0;

    always @(posedge clk) begin
        if (rst_n && dmem_req && dmem_req_ack) begin
            if (dmem_cmd == SCR1_MEM_CMD_RD) begin
                rd_log[rd_n[7:0]] <= dmem_addr;
                rd_n <= rd_n + 1;
            end else if (!acc_is_err) begin
                wr_log_a[wr_n[7:0]] <= dmem_addr;
                wr_log_d[wr_n[7:0]] <= dmem_wdata;
                wr_n <= wr_n + 1;
            end
        end
    end

    // ---------------- protocol monitor ----------------
    logic               held = 1'b0;
    logic [AW-1:0]      h_addr;
    logic [DW-1:0]      h_wdata;
    type_scr1_mem_cmd_e h_cmd;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held <= 1'b0;
        end else begin
            if (held) begin
                check("req_held", dmem_req, 1'b1);
                check("addr_stable", dmem_addr, h_addr);
                check("cmd_stable", dmem_cmd, h_cmd);
                check("wdata_stable", dmem_wdata, h_wdata);
            end
            if (dmem_req) begin
                check("one_outstanding", pend || (dmem_resp != SCR1_MEM_RESP_NOTRDY), 1'b0);
                check("width_word", dmem_width, SCR1_MEM_WIDTH_WORD);
            end
            held    <= dmem_req && !dmem_req_ack;
            h_addr  <= dmem_addr;
            h_cmd   <= dmem_cmd;
            h_wdata <= dmem_wdata;
        end
    end

    // ---------------- stimulus ----------------
    int r_done_cyc, r_done_cnt, r_err_cyc, r_err_cnt;
    int r_busy_first, r_busy_last, r_busy_cnt, r_req_cnt;
    int base_r, base_w;
    logic [31:0] exp_data [5] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};

    task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] n,
                            input int budget, input int inj);
        r_done_cyc = 0; r_done_cnt = 0; r_err_cyc = 0; r_err_cnt = 0;
        r_busy_first = 0; r_busy_last = 0; r_busy_cnt = 0; r_req_cnt = 0;
        base_r = rd_n;
        base_w = wr_n;
        @(negedge clk);
        src_addr = src; dst_addr = dst; len = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Scramble the inputs: a running copy must not look at them again.
        src_addr = 32'hDEAD0000; dst_addr = 32'hBEEF0000; len = 16'd7;
        for (int c = 1; c <= budget; c++) begin
            if (c > 1) @(negedge clk);
            if (busy) begin
                r_busy_cnt++;
                if (r_busy_first == 0) r_busy_first = c;
                r_busy_last = c;
            end
            if (done) begin
                r_done_cnt++;
                if (r_done_cyc == 0) r_done_cyc = c;
            end
            if (err) begin
                r_err_cnt++;
                if (r_err_cyc == 0) r_err_cyc = c;
            end
            if (dmem_req) r_req_cnt++;
            start = (c == inj);
        end
        start = 1'b0;
    endtask

    initial begin
        int found;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_err_addr", err_addr, 32'h0);
        check("rst_req", dmem_req, 1'b0);
        check("rst_cmd", dmem_cmd, SCR1_MEM_CMD_RD);
        check("rst_addr", dmem_addr, 32'h0);
        check("rst_wdata", dmem_wdata, 32'h0);
        rst_n = 1'b1;

        // Zero-wait copy of four words: 4 cycles per word.
        run_copy(32'h100, 32'h200, 16'd4, 24, 0);
        check("t1_done_cyc", r_done_cyc, 17);
        check("t1_done_cnt", r_done_cnt, 1);
        check("t1_busy_first", r_busy_first, 1);
        check("t1_busy_last", r_busy_last, 16);
        check("t1_busy_cnt", r_busy_cnt, 16);
        check("t1_err_cnt", r_err_cnt, 0);
        check("t1_rd_cnt", rd_n - base_r, 4);
        check("t1_wr_cnt", wr_n - base_w, 4);
        for (int k = 0; k < 4; k++) begin
            check("t1_rd_addr", rd_log[base_r + k], 32'h100 + 32'(4 * k));
            check("t1_wr_addr", wr_log_a[base_w + k], 32'h200 + 32'(4 * k));
            check("t1_wr_data", wr_log_d[base_w + k], exp_data[k]);
        end

        // Slow responder: 3 stalled cycles per request, 2 NOTRDY cycles per response.
        ack_wait = 3; resp_wait = 2;
        run_copy(32'h100, 32'h300, 16'd2, 40, 0);
        check("t2_done_cyc", r_done_cyc, 29);
        check("t2_done_cnt", r_done_cnt, 1);
        check("t2_err_cnt", r_err_cnt, 0);
        check("t2_wr_cnt", wr_n - base_w, 2);
        check("t2_wr_addr0", wr_log_a[base_w], 32'h300);
        check("t2_wr_data0", wr_log_d[base_w], 32'h11111111);
        check("t2_wr_addr1", wr_log_a[base_w + 1], 32'h304);
        check("t2_wr_data1", wr_log_d[base_w + 1], 32'h22222222);
        ack_wait = 0; resp_wait = 0;

        // Zero-length start.
        run_copy(32'h100, 32'h300, 16'd0, 8, 0);
        check("t3_done_cyc", r_done_cyc, 1);
        check("t3_done_cnt", r_done_cnt, 1);
        check("t3_req_cnt", r_req_cnt, 0);
        check("t3_busy_cnt", r_busy_cnt, 0);

        // Write error on the third word.
        err_wr_en = 1'b1; err_wr_addr = 32'h208;
        run_copy(32'h100, 32'h200, 16'd5, 30, 0);
        check("t4_err_cnt", r_err_cnt, 1);
        check("t4_err_cyc", r_err_cyc, 13);
        check("t4_done_cnt", r_done_cnt, 0);
        check("t4_err_addr", err_addr, 32'h208);
        check("t4_wr_cnt", wr_n - base_w, 2);
        check("t4_busy_last", r_busy_last, 12);
        check("t4_busy_end", busy, 1'b0);
        err_wr_en = 1'b0;

        // Source address wrap-around.
        run_copy(32'hFFFFFFF8, 32'h400, 16'd3, 20, 0);
        check("t5_err_addr_clr", err_addr, 32'h0);
        check("t5_done_cnt", r_done_cnt, 1);
        check("t5_rd0", rd_log[base_r], 32'hFFFFFFF8);
        check("t5_rd1", rd_log[base_r + 1], 32'hFFFFFFFC);
        check("t5_rd2", rd_log[base_r + 2], 32'h00000000);
        check("t5_wr_data2", wr_log_d[base_w + 2], 32'hA5A50000);
        check("t5_wr_addr2", wr_log_a[base_w + 2], 32'h408);

        // Unaligned start addresses.
        run_copy(32'h103, 32'h502, 16'd1, 10, 0);
        check("t6_done_cyc", r_done_cyc, 5);
        check("t6_rd_addr", rd_log[base_r], 32'h100);
        check("t6_wr_addr", wr_log_a[base_w], 32'h500);
        check("t6_wr_data", wr_log_d[base_w], 32'h11111111);

        // Asynchronous reset while a write request is stalled.
        ack_wait = 3;
        base_w = wr_n;
        @(negedge clk);
        src_addr = 32'h100; dst_addr = 32'h700; len = 16'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 40 && found == 0; c++) begin
            if (dmem_req && dmem_cmd == SCR1_MEM_CMD_WR) found = 1;
            else @(negedge clk);
        end
        check("t7_reached_wr_req", found, 1);
        #1 rst_n = 1'b0;
        #1;
        check("t7_req_dropped", dmem_req, 1'b0);
        check("t7_busy_dropped", busy, 1'b0);
        check("t7_no_done", done, 1'b0);
        check("t7_no_err", err, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        ack_wait = 0;
        check("t7_no_writes", wr_n - base_w, 0);

        // Fresh copy after reset, with a stray start pulse while busy.
        run_copy(32'h100, 32'h600, 16'd2, 16, 3);
        check("t8_done_cyc", r_done_cyc, 9);
        check("t8_done_cnt", r_done_cnt, 1);
        check("t8_err_cnt", r_err_cnt, 0);
        check("t8_wr_cnt", wr_n - base_w, 2);
        check("t8_wr_addr1", wr_log_a[base_w + 1], 32'h604);
        check("t8_wr_data1", wr_log_d[base_w + 1], 32'h22222222);
        check("t8_busy_end", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/scr1_mem_copy_initiator.md
Name: scr1_mem_copy_initiator

Overview:
- Single-channel block-copy engine that acts as an initiator on the core data-memory interface (req/req_ack/cmd/width/addr/wdata/rdata/resp).
- It is the counterpart of TCM-style responders.
- Copies len 32-bit words from src_addr to dst_addr with one outstanding transaction at a time.
- Sits beside the core, for example as a boot/preload mover into TCM, behind a software-visible start/status interface.

Parameters:
- LEN_W, 16, width of the word-count input; max transfer 2^LEN_W-1 words.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle start request; sampled only in IDLE
- src_addr  in  SCR1_DMEM_AWIDTH  source byte address; bits [1:0] ignored (treated as 00)
- dst_addr  in  SCR1_DMEM_AWIDTH  destination byte address; bits [1:0] ignored
- len  in  LEN_W  number of words to copy
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse on successful completion
- err  out  1  one-cycle pulse on error termination
- err_addr  out  SCR1_DMEM_AWIDTH  address of the failing transaction; held until next start
- dmem_req  out  1  request valid
- dmem_req_ack  in  1  request accepted by responder
- dmem_cmd  out  type_scr1_mem_cmd_e  SCR1_MEM_CMD_RD / SCR1_MEM_CMD_WR
- dmem_width  out  type_scr1_mem_width_e  always SCR1_MEM_WIDTH_WORD
- dmem_addr  out  SCR1_DMEM_AWIDTH  word-aligned request address
- dmem_wdata  out  SCR1_DMEM_DWIDTH  write data (last read word)
- dmem_rdata  in  SCR1_DMEM_DWIDTH  read data, valid when dmem_resp==RDY_OK
- dmem_resp  in  type_scr1_mem_resp_e  NOTRDY / RDY_OK / RDY_ER

Behaviour:
- All outputs are registered. Reset values: busy=0, done=0, err=0, err_addr=0, dmem_req=0, dmem_cmd=RD, dmem_addr=0, dmem_wdata=0.
- FSM states: IDLE, RD_REQ, RD_RESP, WR_REQ, WR_RESP.
- IDLE:
  - start=1 with len!=0: latch rd_ptr={src[31:2],00}, wr_ptr={dst[31:2],00}, cnt=len; go RD_REQ; busy=1 from the next cycle.
  - start=1 with len==0: done=1 the next cycle, no bus activity, stay IDLE.
  - start while busy is ignored; len/src/dst changes during a transfer are ignored.
- RD_REQ: dmem_req=1, cmd=RD, addr=rd_ptr.
  - Request and all request fields stay stable until dmem_req & dmem_req_ack at a clock edge.
  - Then go RD_RESP with dmem_req=0 the next cycle.
- RD_RESP: wait any number of cycles while resp==NOTRDY.
  - RDY_OK: capture rdata into dmem_wdata, rd_ptr+=4, go WR_REQ.
  - RDY_ER: error exit.
- WR_REQ: dmem_req=1, cmd=WR, addr=wr_ptr, wdata stable. Same acceptance rule as RD_REQ; go WR_RESP.
- WR_RESP: wait for a response.
  - RDY_OK: wr_ptr+=4, cnt-=1. If cnt was 1: go IDLE, busy=0, done=1 in the same cycle. Otherwise go RD_REQ.
  - RDY_ER: error exit.
- Error exit: err=1 one cycle; err_addr=address of the failed request; busy=0; go IDLE. done is not asserted. Remaining words are not transferred.
- Address arithmetic is modulo 2^SCR1_DMEM_AWIDTH; wrap-around past 0xFFFFFFFC continues at 0x00000000 with no error.
- A response arriving in a *_REQ state (protocol violation) is ignored.
- dmem_req never asserts while a response is outstanding.
- Timing with a zero-wait responder (req_ack=1, resp registered one cycle): 4 cycles per word.
  - start sampled at edge 0 gives the first req in cycle 1.
  - done pulses in cycle 4N+1.
- Async reset mid-transfer: all state and outputs return to reset values immediately; dmem_req drops asynchronously; no done or err pulse.

Test Plan:
- Zero-wait TCM model with words 0x11111111..0x44444444 preloaded at 0x100, start with src=0x100, dst=0x200, len=4 -> 0x200..0x20C match the source, done pulses exactly in cycle 17, busy high cycles 1..16, err never asserts.
- req_ack held low 3 cycles per request and resp delayed 2 cycles, len=2 -> addr/cmd/wdata stable while unacknowledged, one outstanding request max, data copied correctly, done once.
- len=0 start -> done at cycle 1, dmem_req never asserts, busy stays 0.
- Write to 0x208 returns RDY_ER on the third word of a len=5 copy to 0x200 -> err pulse, err_addr=0x208, no done, only 2 words written, busy=0.
- src=0xFFFFFFF8, len=3 -> read addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 in order; src=0x103 is treated as 0x100.
- rst_n asserted while in WR_REQ -> dmem_req=0 immediately, busy=0; a fresh start after release runs a full copy normally. start pulses while busy are ignored.
